uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Synthesizable UART receiver for the slave end of the UART link.
- Deserializes the serial line driven by the master transmitter into parallel bytes, with parity, framing and overrun checking.
- Sits in the slave-side RTL under hdl_top and hands bytes to the slave fabric over a valid/ready handshake.
- Lets the master-side agent exercise a real receiver instead of only a passive observer.

Parameters:
- OVERSAMPLE, 16, baud ticks per serial bit; must be even and at least 4.
- DATA_BITS, 8, data bits per frame (5..8), sent LSB first.
- PARITY_EN, 1, 1 means a parity bit follows the data.
- PARITY_ODD, 0, 0 selects even parity; 1 selects odd parity.
- DIV_WIDTH, 16, width of the baud divisor.

Ports:
- pclk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- baud_div  input  DIV_WIDTH  pclk cycles per baud tick; 0 is treated as 1.
- rx  input  1  serial line; idles high; asynchronous to pclk.
- rx_data  output  DATA_BITS  received byte.
- rx_valid  output  1  rx_data and error flags are valid.
- rx_ready  input  1  consumer accepts the byte.
- rx_parity_err  output  1  parity mismatch on the held byte.
- rx_frame_err  output  1  stop bit sampled low on the held byte.
- rx_overrun  output  1  one-cycle pulse: a completed byte was dropped.
- rx_busy  output  1  receiver is not in IDLE.

Behaviour:
- Interface: one clock, pclk. Reset rst is synchronous and active-high; it is sampled only on the pclk rising edge.
- Reset values:
  - All outputs 0.
  - FSM in IDLE; tick and bit counters at 0.
  - Both synchronizer flops at 1.
- Synchronizer: rx passes through two flops before any use (rx_s). This adds 2 cycles of input latency.
- Baud tick generator:
  - Counter runs 0..max(baud_div,1)-1; tick pulses for 1 cycle at the terminal count, then the counter wraps to 0.
  - A change to baud_div takes effect at the next wrap.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. All sampling happens only on tick cycles.
- IDLE: when rx_s is 0 on a tick, go to START with the tick counter at 0.
- START:
  - After OVERSAMPLE/2 ticks, sample rx_s.
  - If 1: false start (glitch), return to IDLE.
  - If 0: go to DATA and reset the tick counter. This sets the mid-bit phase.
- DATA:
  - Every OVERSAMPLE ticks, sample one bit into a shift register, LSB first.
  - After DATA_BITS samples, go to PARITY if PARITY_EN is 1, else to STOP.
- PARITY:
  - Sample one bit after OVERSAMPLE ticks.
  - perr = XOR(data bits, parity bit) XOR PARITY_ODD; perr must be 0 for a good frame.
- STOP:
  - Sample after OVERSAMPLE ticks; frame error if the sample is 0.
  - Complete the frame: IDLE if stop = 1, WAIT_IDLE if stop = 0.
- WAIT_IDLE: stay until rx_s is 1 on a tick, then go to IDLE. A break condition therefore never re-triggers a start.
- Completion timing: the byte is committed on the cycle after the stop-sample tick. rx_valid rises 1 cycle after that tick.
- Output holding register (1 entry):
  - Accept: rx_valid && rx_ready on a cycle clears rx_valid on the next cycle, unless a commit occurs on the same cycle.
  - Commit while the register is empty, or while it is being accepted on the same cycle: load rx_data and both error flags, and set rx_valid.
  - Commit while rx_valid && !rx_ready: drop the new byte. The held rx_data and flags are unchanged, and rx_overrun pulses 1 cycle.
- Error flags are qualified by rx_valid and update only on load.
- Reset mid-frame: the partial frame is discarded, no rx_valid is produced, and reception resumes with start detection.
- rx_busy = (state != IDLE).
- With the example configuration (OVERSAMPLE 16, baud_div 4), a nominal frame of 11 bits takes 11 × 64 = 704 cycles.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum uart_rx_state_e;
  - OVERSAMPLE_DEFAULT and DATA_BITS_MAX = 8;
  - a function parity_calc(data, odd).
- Sub-module uart_baud_tick_gen (pclk, rst, baud_div → tick), reusable by the future transmitter.

Test Plan:
- Good byte:
  - Stimulus: baud_div 4, OVERSAMPLE 16, 0xA5 with even parity (frame 0, 1010 0101 LSB first, parity 0, stop 1).
  - Response: rx_data 0xA5, rx_valid 1, both error flags 0, rx_valid rising 1 cycle after the stop-sample tick.
- Glitch rejection: rx low for 20 cycles (less than the 32-cycle half bit), then high → no rx_valid; FSM back in IDLE; rx_busy low within 40 cycles.
- Parity error: 0x01 sent with parity bit 0 under even parity → rx_data 0x01, rx_parity_err 1, rx_frame_err 0.
- Framing error and break:
  - Stimulus: 0x3C with stop = 0, line held low for 200 more cycles.
  - Response: rx_data 0x3C with rx_frame_err 1; FSM stays in WAIT_IDLE; no second byte until the line goes high and a new start arrives.
- Overrun:
  - Stimulus: rx_ready held 0 while 0x11 then 0x22 are sent.
  - Response: rx_data stays 0x11 and rx_valid stays 1; rx_overrun pulses exactly 1 cycle at the 0x22 commit; rx_ready = 1 then clears rx_valid.
- Reset mid-frame: rst = 1 for 1 cycle during data bit 3 of 0x5A, then a clean 0xC3 → no output for 0x5A; 0xC3 received correctly; outputs 0 in the cycle after reset.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } uart_rx_state_e;

    localparam int unsigned OVERSAMPLE_DEFAULT = 16;
    localparam int unsigned DATA_BITS_MAX      = 8;

    // Parity bit a transmitter would send for this data; unused upper bits must be zero.
    function automatic logic parity_calc(input logic [DATA_BITS_MAX-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte handshake between the receiver (master) and the slave fabric (slave).
interface uart_rx_if
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_MAX
) ();

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    modport master (
        output rx_data, rx_valid, rx_parity_err, rx_frame_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, rx_parity_err, rx_frame_err,
        output rx_ready
    );

endinterface

// File: rtl/uart_baud_tick_gen.sv
// Baud tick generator: one-cycle tick every max(baud_div,1) pclk cycles.
module uart_baud_tick_gen #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] baud_div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] term_q, term_d;
    logic [DIV_WIDTH-1:0] term_new;

    // Terminal count is latched at each wrap so a divisor change never truncates a period.
    always_comb begin
        term_new = (baud_div == '0) ? '0 : baud_div - DIV_WIDTH'(1);
        tick     = (cnt_q == term_q);
        cnt_d    = tick ? '0 : cnt_q + DIV_WIDTH'(1);
        term_d   = tick ? term_new : term_q;
    end

    // Counter and latched terminal count.
    always_ff @(posedge pclk) begin
        if (rst) begin
            cnt_q  <= '0;
            term_q <= term_new;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled start detection, LSB-first deserialisation,
// parity/framing checks and a one-entry output holding register.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int unsigned DATA_BITS  = 8,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 rx,
    uart_rx_if.master            rx_if,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS_MAX);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic tick;

    uart_baud_tick_gen #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_tick (
        .pclk    (pclk),
        .rst     (rst),
        .baud_div(baud_div),
        .tick    (tick)
    );

    logic                 sync1_q, rx_s_q;
    uart_rx_state_e       state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 stop_sample;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_hold_q, perr_hold_d;
    logic                 ferr_q, ferr_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;

    // Frame FSM: every decision is taken on a baud tick; the START half-bit wait fixes mid-bit sampling.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        perr_d      = perr_q;
        stop_sample = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_d    = ST_START;
                        tick_cnt_d = '0;
                    end
                end
                ST_START: begin
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        perr_d     = 1'b0;
                        state_d    = rx_s_q ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        shreg_d    = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = PARITY_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                ST_PARITY: begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        perr_d     = parity_calc(DATA_BITS_MAX'(shreg_q), PARITY_ODD) ^ rx_s_q;
                        state_d    = ST_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d  = '0;
                        stop_sample = 1'b1;
                        state_d     = rx_s_q ? ST_IDLE : ST_WAIT_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_s_q) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Holding register: load on commit when empty or being drained, otherwise drop and flag overrun.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        perr_hold_d = perr_hold_q;
        ferr_d      = ferr_q;
        overrun_d   = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        if (valid_q && rx_if.rx_ready) valid_d = 1'b0;
        if (stop_sample) begin
            if (!valid_q || rx_if.rx_ready) begin
                data_d      = shreg_q;
                perr_hold_d = perr_q;
                ferr_d      = !rx_s_q;
                valid_d     = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State, synchroniser and output registers; rx is asynchronous so it goes through two flops first.
    always_ff @(posedge pclk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            perr_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_hold_q <= 1'b0;
            ferr_q      <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync1_q     <= rx;
            rx_s_q      <= sync1_q;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            perr_q      <= perr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_hold_q <= perr_hold_d;
            ferr_q      <= ferr_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_if.rx_data       = data_q;
    assign rx_if.rx_valid      = valid_q;
    assign rx_if.rx_parity_err = perr_hold_q;
    assign rx_if.rx_frame_err  = ferr_q;
    assign rx_overrun          = overrun_q;
    assign rx_busy             = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: frames are driven from byte values and
// expected byte, flags and output timing are derived from baud arithmetic.
module tb_uart_rx_core;

    localparam int OS  = 16;
    localparam int DB  = 8;
    localparam int DW  = 16;
    localparam bit ODD = 1'b0;

    logic          pclk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] baud_div = 16'd4;
    logic          rx = 1'b1;
    logic          rx_overrun;
    logic          rx_busy;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx_core #(
        .OVERSAMPLE(OS),
        .DATA_BITS (DB),
        .PARITY_EN (1'b1),
        .PARITY_ODD(ODD),
        .DIV_WIDTH (DW)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .baud_div  (baud_div),
        .rx        (rx),
        .rx_if     (bus.master),
        .rx_overrun(rx_overrun),
        .rx_busy   (rx_busy)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int base = 0;
    int div_eff = 4;
    int checks = 0;
    int errors = 0;

    // Monitor: record each rx_valid rise (cycle, byte, flags) and every overrun cycle.
    int         rise_q[$];
    logic [7:0] dat_q[$];
    logic       pe_q[$];
    logic       fe_q[$];
    int         ovr_q[$];
    logic       prev_valid = 1'b0;

    always @(negedge pclk) begin
        if (bus.rx_valid === 1'b1 && !prev_valid) begin
            rise_q.push_back(cyc);
            dat_q.push_back(bus.rx_data);
            pe_q.push_back(bus.rx_parity_err);
            fe_q.push_back(bus.rx_frame_err);
        end
        if (rx_overrun === 1'b1) ovr_q.push_back(cyc);
        prev_valid = (bus.rx_valid === 1'b1);
    end

    task automatic clear_mon();
        rise_q.delete(); dat_q.delete(); pe_q.delete(); fe_q.delete(); ovr_q.delete();
    endtask

    task automatic do_reset(input int div);
        baud_div = DW'(div);
        div_eff  = (div == 0) ? 1 : div;
        @(posedge pclk); #1 rst = 1'b1;
        repeat (2) @(posedge pclk);
        #1 rst = 1'b0;
        base = cyc;
    endtask

    // Ticks fall on cycles where (c - base) mod div == div-1; the first one seeing the
    // synchronised start edge launches the frame, then half a bit plus ten full bits to stop.
    function automatic int exp_rise(input int s);
        int d;
        d = s + 2;
        while (((d - base) % div_eff) != div_eff - 1) d++;
        return d + (OS / 2 + OS * (DB + 2)) * div_eff + 1;
    endfunction

    function automatic logic good_par(input logic [7:0] data);
        return logic'(($countones(data) + int'(ODD)) % 2);
    endfunction

    function automatic logic model_perr(input logic [7:0] data, input logic par);
        return logic'(($countones(data) + int'(par) + int'(ODD)) % 2);
    endfunction

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop, output int s);
        int bt;
        bt = OS * div_eff;
        @(posedge pclk); #1 rx = 1'b0; s = cyc;
        repeat (bt) @(posedge pclk);
        for (int i = 0; i < DB; i++) begin
            #1 rx = data[i];
            repeat (bt) @(posedge pclk);
        end
        #1 rx = par;
        repeat (bt) @(posedge pclk);
        #1 rx = stop;
        repeat (bt) @(posedge pclk);
    endtask

    task automatic idle(input int n);
        #1 rx = 1'b1;
        repeat (n) @(posedge pclk);
    endtask

    task automatic test_reset();
        @(negedge pclk);
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.rx_valid); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.rx_data); end
        checks++; if (bus.rx_parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", bus.rx_parity_err); end
        checks++; if (bus.rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", bus.rx_frame_err); end
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", rx_overrun); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    endtask

    task automatic test_good_byte();
        int s;
        clear_mon();
        bus.rx_ready = 1'b1;
        send_frame(8'hA5, good_par(8'hA5), 1'b1, s);
        idle(40);
        checks++; if (rise_q.size() != 1) begin errors++; $display("FAIL good_count: got %0d expected 1", rise_q.size()); end
        else begin
            checks++; if (dat_q[0] !== 8'hA5) begin errors++; $display("FAIL good_data: got %h expected a5", dat_q[0]); end
            checks++; if (pe_q[0] !== 1'b0 || fe_q[0] !== 1'b0) begin errors++; $display("FAIL good_flags: got %b%b expected 00", pe_q[0], fe_q[0]); end
            checks++; if (rise_q[0] != exp_rise(s)) begin errors++; $display("FAIL good_timing: got %0d expected %0d", rise_q[0], exp_rise(s)); end
        end
    endtask

    task automatic test_glitch();
        int s;
        int n;
        clear_mon();
        @(posedge pclk); #1 rx = 1'b0; s = cyc;
        repeat (19) @(posedge pclk);
        #1;
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b expected 1", rx_busy); end
        @(posedge pclk); #1 rx = 1'b1;
        n = 0;
        while (rx_busy !== 1'b0 && n < 40) begin
            @(posedge pclk); #1; n++;
        end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b expected 0 within 40 cycles", rx_busy); end
        repeat (800) @(posedge pclk);
        checks++; if (rise_q.size() != 0) begin errors++; $display("FAIL glitch_no_valid: got %0d bytes expected 0", rise_q.size()); end
    endtask

    task automatic test_parity_err();
        int s;
        clear_mon();
        send_frame(8'h01, 1'b0, 1'b1, s);
        idle(40);
        checks++; if (rise_q.size() != 1) begin errors++; $display("FAIL perr_count: got %0d expected 1", rise_q.size()); end
        else begin
            checks++; if (dat_q[0] !== 8'h01) begin errors++; $display("FAIL perr_data: got %h expected 01", dat_q[0]); end
            checks++; if (pe_q[0] !== model_perr(8'h01, 1'b0)) begin errors++; $display("FAIL perr_flag: got %b expected %b", pe_q[0], model_perr(8'h01, 1'b0)); end
            checks++; if (fe_q[0] !== 1'b0) begin errors++; $display("FAIL perr_ferr: got %b expected 0", fe_q[0]); end
        end
    endtask

    task automatic test_break();
        int s;
        clear_mon();
        send_frame(8'h3C, good_par(8'h3C), 1'b0, s);
        repeat (200) @(posedge pclk);
        #1;
        checks++; if (rise_q.size() != 1) begin errors++; $display("FAIL break_count: got %0d expected 1", rise_q.size()); end
        else begin
            checks++; if (dat_q[0] !== 8'h3C || fe_q[0] !== 1'b1 || pe_q[0] !== 1'b0) begin
                errors++; $display("FAIL break_byte: got %h pe %b fe %b expected 3c pe 0 fe 1", dat_q[0], pe_q[0], fe_q[0]);
            end
        end
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL break_busy: got %b expected 1", rx_busy); end
        idle(200);
        checks++; if (rx_busy !== 1'b0 || rise_q.size() != 1) begin
            errors++; $display("FAIL break_release: got busy %b bytes %0d expected busy 0 bytes 1", rx_busy, rise_q.size());
        end
        send_frame(8'h96, good_par(8'h96), 1'b1, s);
        idle(40);
        checks++; if (rise_q.size() != 2) begin errors++; $display("FAIL break_next_count: got %0d expected 2", rise_q.size()); end
        else begin
            checks++; if (dat_q[1] !== 8'h96 || fe_q[1] !== 1'b0 || rise_q[1] != exp_rise(s)) begin
                errors++; $display("FAIL break_next_byte: got %h fe %b at %0d expected 96 fe 0 at %0d", dat_q[1], fe_q[1], rise_q[1], exp_rise(s));
            end
        end
    endtask

    task automatic test_overrun();
        int s1;
        int s2;
        clear_mon();
        bus.rx_ready = 1'b0;
        send_frame(8'h11, good_par(8'h11), 1'b1, s1);
        idle(32);
        send_frame(8'h22, good_par(8'h22), 1'b1, s2);
        idle(64);
        #1;
        checks++; if (rise_q.size() != 1 || bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h11) begin
            errors++; $display("FAIL ovr_hold: got rises %0d valid %b data %h expected 1 1 11", rise_q.size(), bus.rx_valid, bus.rx_data);
        end
        checks++; if (ovr_q.size() != 1) begin errors++; $display("FAIL ovr_pulse_count: got %0d expected 1", ovr_q.size()); end
        else begin
            checks++; if (ovr_q[0] != exp_rise(s2)) begin errors++; $display("FAIL ovr_pulse_cycle: got %0d expected %0d", ovr_q[0], exp_rise(s2)); end
        end
        @(posedge pclk); #1 bus.rx_ready = 1'b1;
        @(posedge pclk); #1 bus.rx_ready = 1'b0;
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept: got valid %b expected 0", bus.rx_valid); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        int s;
        int bt;
        clear_mon();
        bus.rx_ready = 1'b1;
        bt = OS * div_eff;
        b = 8'h5A;
        @(posedge pclk); #1 rx = 1'b0;
        repeat (bt) @(posedge pclk);
        for (int i = 0; i < 3; i++) begin
            #1 rx = b[i];
            repeat (bt) @(posedge pclk);
        end
        #1 rx = b[3];
        repeat (24) @(posedge pclk);
        #1;
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", rx_busy); end
        rst = 1'b1;
        @(posedge pclk); #1 rst = 1'b0; base = cyc;
        checks++; if ({bus.rx_valid, bus.rx_data, bus.rx_parity_err, bus.rx_frame_err, rx_overrun, rx_busy} !== 13'h0) begin
            errors++; $display("FAIL mid_reset_outputs: got valid %b data %h pe %b fe %b ovr %b busy %b expected all 0",
                bus.rx_valid, bus.rx_data, bus.rx_parity_err, bus.rx_frame_err, rx_overrun, rx_busy);
        end
        idle(200);
        checks++; if (rise_q.size() != 0) begin errors++; $display("FAIL mid_no_output: got %0d bytes expected 0", rise_q.size()); end
        send_frame(8'hC3, good_par(8'hC3), 1'b1, s);
        idle(40);
        checks++; if (rise_q.size() != 1) begin errors++; $display("FAIL mid_next_count: got %0d expected 1", rise_q.size()); end
        else begin
            checks++; if (dat_q[0] !== 8'hC3 || pe_q[0] !== 1'b0 || fe_q[0] !== 1'b0 || rise_q[0] != exp_rise(s)) begin
                errors++; $display("FAIL mid_next_byte: got %h pe %b fe %b at %0d expected c3 0 0 at %0d", dat_q[0], pe_q[0], fe_q[0], rise_q[0], exp_rise(s));
            end
        end
    endtask

    task automatic test_random();
        int divs[3];
        logic [7:0] d;
        logic par;
        logic stop;
        int s;
        divs[0] = 0;
        divs[1] = int'($urandom_range(1, 5));
        divs[2] = int'($urandom_range(2, 6));
        bus.rx_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            do_reset(divs[r]);
            idle(8);
            for (int n = 0; n < 4; n++) begin
                clear_mon();
                d    = 8'($urandom);
                par  = ($urandom_range(0, 2) == 0) ? ~good_par(d) : good_par(d);
                stop = ($urandom_range(0, 3) != 0);
                send_frame(d, par, stop, s);
                idle(OS * div_eff * 2);
                checks++; if (rise_q.size() != 1) begin errors++; $display("FAIL rnd_count div %0d: got %0d expected 1", divs[r], rise_q.size()); end
                else begin
                    checks++; if (dat_q[0] !== d || pe_q[0] !== model_perr(d, par) || fe_q[0] !== !stop) begin
                        errors++; $display("FAIL rnd_byte div %0d: got %h pe %b fe %b expected %h pe %b fe %b",
                            divs[r], dat_q[0], pe_q[0], fe_q[0], d, model_perr(d, par), !stop);
                    end
                    checks++; if (rise_q[0] != exp_rise(s)) begin errors++; $display("FAIL rnd_timing div %0d: got %0d expected %0d", divs[r], rise_q[0], exp_rise(s)); end
                end
            end
        end
    endtask

    initial begin
        bus.rx_ready = 1'b0;
        do_reset(4);
        test_reset();
        test_good_byte();
        test_glitch();
        test_parity_err();
        test_break();
        test_overrun();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
